// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
// Parallel-to-serial converter. A WIDTH-bit word is shifted out MSB first,
// one bit per clock, with a valid strobe on every bit. Only the top N bits
// are sent; N comes from data_mod_i (0 selects all WIDTH bits).
//
// Ports
//   clk_i          : clock, all logic on the rising edge
//   srst_i         : asynchronous active-high reset
//   data_i         : parallel word, bit WIDTH-1 is transmitted first
//   data_mod_i     : number of valid bits from the MSB (0 = WIDTH, 1..2 illegal)
//   data_val_i     : request strobe, sampled when busy_o is low
//   ser_data_o     : serial data bit (0 whenever ser_data_val_o is low)
//   ser_data_val_o : high on every cycle carrying a valid bit
//   busy_o         : high while new requests are ignored
// -----------------------------------------------------------------------------
module serializer #(
    parameter int WIDTH = 16,
    parameter int MOD_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             data_val_i,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [MOD_W-1:0] r_cnt;
    logic [MOD_W-1:0] w_cnt_nxt;
    logic             r_ser_data;
    logic             w_ser_data_nxt;
    logic             r_ser_val;
    logic             w_ser_val_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_accept;
    logic [MOD_W-1:0] w_last_idx;

    // Counts of 1 and 2 are rejected; 0 and 3..WIDTH-1 are accepted.
    function automatic logic mod_legal(input logic [MOD_W-1:0] mod);
        return (mod == '0) || (mod > MOD_W'(2));
    endfunction

    // Index of the last bit relative to the first, i.e. N-1. The counter holds
    // the number of bits still to follow the one currently on ser_data_o.
    function automatic logic [MOD_W-1:0] last_idx(input logic [MOD_W-1:0] mod);
        return (mod == '0) ? MOD_W'(WIDTH - 1) : (mod - MOD_W'(1));
    endfunction

    // busy_o is low only in IDLE and on the last-bit cycle, so this also
    // enables the back-to-back reload without a gap.
    assign w_accept   = data_val_i && !r_busy && mod_legal(data_mod_i);
    assign w_last_idx = last_idx(data_mod_i);

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_ser_data_nxt = 1'b0;
        w_ser_val_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;

        if (w_accept) begin
            // The MSB goes straight to the output register; the rest waits.
            w_state_nxt    = SHIFT;
            w_ser_data_nxt = data_i[WIDTH-1];
            w_ser_val_nxt  = 1'b1;
            w_shift_nxt    = {data_i[WIDTH-2:0], 1'b0};
            w_cnt_nxt      = w_last_idx;
            w_busy_nxt     = (w_last_idx != '0);
        end else if (r_state == SHIFT) begin
            if (r_cnt != '0) begin
                w_ser_data_nxt = r_shift[WIDTH-1];
                w_ser_val_nxt  = 1'b1;
                w_shift_nxt    = {r_shift[WIDTH-2:0], 1'b0};
                w_cnt_nxt      = r_cnt - MOD_W'(1);
                w_busy_nxt     = (r_cnt != MOD_W'(1));
            end else begin
                w_state_nxt = IDLE;
                w_shift_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ser_data <= 1'b0;
            r_ser_val  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ser_data <= w_ser_data_nxt;
            r_ser_val  <= w_ser_val_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign ser_data_o     = r_ser_data;
    assign ser_data_val_o = r_ser_val;
    assign busy_o         = r_busy;

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
// Scoreboard bench: stimulus pushes the expected {bit, busy} sequence of every
// word it issues; a monitor pops one entry per valid output cycle.
// -----------------------------------------------------------------------------
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    // Each entry: [1] = expected data bit, [0] = expected busy_o.
    logic [1:0] sb[$];

    serializer #(.WIDTH(16), .MOD_W(4)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Push the first n bits of d, MSB first; busy is 1 on all but the last.
    task automatic push_bits(input logic [15:0] d, input int n, input int total);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = d[15-i];
            sb.push_back({b, (i != total - 1) ? 1'b1 : 1'b0});
        end
    endtask

    function automatic int nbits(input logic [3:0] m);
        return (m == 4'd0) ? 16 : int'(m);
    endfunction

    // Called at posedge+1 with the DUT idle.
    task automatic send_word(input logic [15:0] d, input logic [3:0] m);
        int n;
        n = nbits(m);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        push_bits(d, n, n);
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
        chk("val_low_after_word", int'(ser_data_val_o), 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    // Monitor
    always @(negedge clk_i) begin
        if (srst_i === 1'b0) begin
            if (ser_data_val_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid_bit", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = sb.pop_front();
                    chk("ser_bit", int'(ser_data_o), int'(e[1]));
                    chk("busy_in_word", int'(busy_o), int'(e[0]));
                end
            end else begin
                chk("data_zero_when_idle", int'(ser_data_o), 0);
                chk("busy_zero_when_idle", int'(busy_o), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst_i     = 1'b1;
        data_i     = '0;
        data_mod_i = '0;
        data_val_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_data", int'(ser_data_o), 0);
        chk("rst_val", int'(ser_data_val_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        srst_i = 1'b0;
        @(posedge clk_i); #1;

        // Full word and a short word.
        send_word(16'hA5C3, 4'd0);
        send_word(16'hF000, 4'd5);
        send_word(16'hA000, 4'd3);

        // Illegal counts are dropped.
        data_i     = 16'hFFFF;
        data_mod_i = 4'd1;
        data_val_i = 1'b1;
        @(posedge clk_i); #1;
        chk("mod1_no_val", int'(ser_data_val_o), 0);
        chk("mod1_no_busy", int'(busy_o), 0);
        data_mod_i = 4'd2;
        @(posedge clk_i); #1;
        chk("mod2_no_val", int'(ser_data_val_o), 0);
        chk("mod2_no_busy", int'(busy_o), 0);
        data_val_i = 1'b0;
        @(posedge clk_i); #1;
        chk("mod2_still_idle", int'(ser_data_val_o), 0);
        send_word(16'h8001, 4'd0);

        // Back-to-back with data_val_i held high: new data on the last-bit cycle.
        data_i     = 16'hFFFF;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
        push_bits(16'hFFFF, 16, 16);
        push_bits(16'h0000, 16, 16);
        @(posedge clk_i); #1;
        repeat (15) @(posedge clk_i);
        #1;
        data_i = 16'h0000;
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        repeat (16) @(posedge clk_i);
        #1;
        chk("b2b_val_low", int'(ser_data_val_o), 0);
        chk("b2b_sb_drained", sb.size(), 0);

        // Request while busy is ignored.
        data_i     = 16'h1234;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
        push_bits(16'h1234, 16, 16);
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("busy_during_shift", int'(busy_o), 1);
        data_i     = 16'hFFFF;
        data_mod_i = 4'd5;
        data_val_i = 1'b1;
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        data_i     = 16'h0000;
        repeat (12) @(posedge clk_i);
        #1;
        chk("ignored_val_low", int'(ser_data_val_o), 0);
        chk("ignored_sb_drained", sb.size(), 0);

        // Asynchronous reset during bit 7 aborts the word.
        data_i     = 16'hFFFF;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
        push_bits(16'hFFFF, 7, 16);
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #3;
        chk("pre_rst_val", int'(ser_data_val_o), 1);
        srst_i = 1'b1;
        #1;
        chk("async_rst_data", int'(ser_data_o), 0);
        chk("async_rst_val", int'(ser_data_val_o), 0);
        chk("async_rst_busy", int'(busy_o), 0);
        @(posedge clk_i); #3;
        srst_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("post_rst_val", int'(ser_data_val_o), 0);
        chk("post_rst_sb_drained", sb.size(), 0);
        send_word(16'h3C5A, 4'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
